// File: rtl/ibex_rvfi_trace_buffer.sv
// Retirement-trace capture buffer: stores a reduced RVFI record per retirement in a
// first-word-fall-through FIFO and presents it on a valid/ready stream. Also counts
// dropped records and flags discontinuities in rvfi_order.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth      = 8,
    parameter bit          CheckOrder = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     rvfi_valid,
    input  logic [63:0]              rvfi_order,
    input  logic [31:0]              rvfi_insn,
    input  logic                     rvfi_trap,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,

    input  logic                     flush_i,

    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output logic [63:0]              trace_order_o,
    output logic [31:0]              trace_pc_o,
    output logic [31:0]              trace_insn_o,
    output logic                     trace_trap_o,
    output logic [4:0]               trace_rd_addr_o,
    output logic [31:0]              trace_rd_wdata_o,

    output logic [$clog2(Depth):0]   count_o,
    output logic [15:0]              overflow_cnt_o,
    output logic                     order_err_o
);

    localparam int unsigned AW = $clog2(Depth);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } entry_t;

    entry_t        mem_q [Depth];
    entry_t        head;
    entry_t        new_entry;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [15:0]   ovf_cnt_q;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A full buffer still accepts a record when the head leaves in the same cycle.
    assign pop  = ~empty & trace_ready_i;
    assign push = rvfi_valid & ~flush_i & (~full | pop);
    assign drop = rvfi_valid & ~flush_i & full & ~pop;

    assign new_entry = '{
        order:    rvfi_order,
        pc:       rvfi_pc_rdata,
        insn:     rvfi_insn,
        trap:     rvfi_trap,
        rd_addr:  rvfi_rd_addr,
        rd_wdata: rvfi_rd_wdata
    };

    // Storage write; contents need no reset since outputs are masked when empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx] <= new_entry;
        end
    end

    // Pointer update; flush wins over push and pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Saturating count of records lost to a full buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    // Head record drive, zeroed whenever no record is valid.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_q[rd_idx];
        end
    end

    assign trace_valid_o    = ~empty;
    assign trace_order_o    = head.order;
    assign trace_pc_o       = head.pc;
    assign trace_insn_o     = head.insn;
    assign trace_trap_o     = head.trap;
    assign trace_rd_addr_o  = head.rd_addr;
    assign trace_rd_wdata_o = head.rd_wdata;
    assign count_o          = wr_ptr_q - rd_ptr_q;
    assign overflow_cnt_o   = ovf_cnt_q;

    if (CheckOrder) begin : g_order_check
        logic [63:0] exp_order_q;
        logic        exp_vld_q;
        logic        order_err_q;

        // Every retirement (kept, dropped or flushed) is checked and sets the next baseline.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                exp_order_q <= '0;
                exp_vld_q   <= 1'b0;
                order_err_q <= 1'b0;
            end else if (rvfi_valid) begin
                if (exp_vld_q && (rvfi_order != exp_order_q)) begin
                    order_err_q <= 1'b1;
                end
                exp_order_q <= rvfi_order + 64'd1;
                exp_vld_q   <= 1'b1;
            end
        end

        assign order_err_o = order_err_q;
    end else begin : g_no_order_check
        assign order_err_o = 1'b0;
    end

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
# ibex_rvfi_trace_buffer

Retirement-trace capture buffer that sits directly downstream of the traced Ibex top level. It consumes the RVFI retirement stream (one record per `rvfi_valid` cycle), stores a reduced record in a first-word-fall-through FIFO, and presents it on a valid/ready stream for a trace sink. The sink is a debug port, a DPI logger or the lockstep trace comparator. It also counts dropped records and flags gaps or reordering in `rvfi_order`.

## Interface

Parameters:
- `Depth`, 8: FIFO entries. Must be a power of two and at least 2.
- `CheckOrder`, 1'b1: enables the `rvfi_order` continuity check. When 0, `order_err_o` is tied to 0.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_ni`, in, 1: synchronous active-low reset.
- `rvfi_valid`, in, 1: a retirement record is present this cycle.
- `rvfi_order`, in, 64: retirement index.
- `rvfi_insn`, in, 32: retired instruction word.
- `rvfi_trap`, in, 1: the instruction trapped.
- `rvfi_pc_rdata`, in, 32: PC of the retired instruction.
- `rvfi_rd_addr`, in, 5: destination register.
- `rvfi_rd_wdata`, in, 32: destination write data.
- `flush_i`, in, 1: discard all buffered records.
- `trace_valid_o`, out, 1: head record is valid.
- `trace_ready_i`, in, 1: sink accepts the head record.
- `trace_order_o`, out, 64: head record, order field.
- `trace_pc_o`, out, 32: head record, PC field.
- `trace_insn_o`, out, 32: head record, instruction field.
- `trace_trap_o`, out, 1: head record, trap field.
- `trace_rd_addr_o`, out, 5: head record, destination register field.
- `trace_rd_wdata_o`, out, 32: head record, destination data field.
- `count_o`, out, $clog2(Depth)+1: number of occupied entries.
- `overflow_cnt_o`, out, 16: dropped-record counter. Saturates at 16'hFFFF.
- `order_err_o`, out, 1: sticky order-discontinuity flag.

## Operation

- Storage is a circular buffer with `Depth` entries.
- Pointers are $clog2(Depth) bits plus a wrap bit. `full` is defined as "indices equal and wrap bits differ". `empty` is defined as "pointers equal".
- Push occurs when `rvfi_valid` is high, `flush_i` is low, and either `!full` or a pop happens in the same cycle. A push when full with a simultaneous pop is accepted.
- Drop occurs when `rvfi_valid` is high, `flush_i` is low, `full` is set and there is no pop. On a drop, `overflow_cnt_o` increments, saturating at 16'hFFFF and never wrapping.
- Pop occurs when `trace_valid_o` and `trace_ready_i` are both high.
- `trace_valid_o` equals `!empty`. The `trace_*` data fields are driven combinationally from the head entry.
- When `trace_valid_o` is low, the `trace_*` data outputs are all zero.
- `count_o` equals the write pointer minus the read pointer, with wrap bits included.
- Simultaneous push and pop on a non-empty, non-full buffer leaves `count_o` unchanged.
- Flush sets both pointers to 0 on the next edge. Flush has priority over push and pop: a record arriving in the flush cycle is discarded and not counted as a drop. A flush does not clear `overflow_cnt_o` or `order_err_o`.
- Order check (`CheckOrder`=1):
  - The block holds registers `exp_order` (64 bits) and `exp_vld`.
  - On every `rvfi_valid` cycle (pushed, dropped or flushed), if `exp_vld` is set and `rvfi_order != exp_order`, `order_err_o` is set.
  - On every `rvfi_valid` cycle, `exp_order` is loaded with `rvfi_order + 1` (64-bit, wrapping) and `exp_vld` is set.
  - The first record after reset establishes the baseline and is never flagged.
- Reset values: pointers 0, `trace_valid_o`=0, all `trace_*` data outputs 0, `count_o`=0, `overflow_cnt_o`=0, `order_err_o`=0, `exp_vld`=0.
- Reset takes effect only at a clock edge. A reset in the middle of a stream discards the buffered contents, and the next record re-establishes the order baseline.

## Timing

- A record pushed at edge N is visible on `trace_valid_o` and `trace_*` in the cycle after edge N. Latency from `rvfi_valid` to `trace_valid_o` is 1 cycle.
- Sustained throughput is 1 record per cycle when `trace_ready_i` is held high.
- A pop at edge N exposes the next entry in the cycle after edge N. There is no bubble.
- `trace_ready_i` may toggle freely. The head record is stable while `trace_valid_o` is high and no pop occurs.
- `overflow_cnt_o`, `order_err_o` and `count_o` are registered. Each updates 1 cycle after the causing event.
- There is no combinational path from `trace_ready_i` to any RVFI-side input.

## Test plan

- **Basic capture.** Reset, then apply 3 records with order 0,1,2, PCs 0x100/0x104/0x108 and `trace_ready_i`=1. Required: 3 records out in order, each 1 cycle after input, `count_o` peaks at 1, `order_err_o`=0.
- **Fill and overflow.** `Depth`=8, `trace_ready_i`=0, 10 consecutive records. Required: `count_o`=8, `overflow_cnt_o`=2. After releasing `trace_ready_i`, orders 0..7 drain and then `trace_valid_o`=0.
- **Full push with pop.** With the buffer full, in the same cycle `trace_ready_i`=1 and record order 8 is presented. Required: push accepted, `count_o` stays 8, `overflow_cnt_o` unchanged, order 8 is the last record drained.
- **Order gap.** Records with order 5, 6, 8. Required: `order_err_o` rises 1 cycle after the order-8 record. It is still set after a subsequent `flush_i` and is cleared only by `rst_ni`=0.
- **Flush with push.** 4 records buffered, then `flush_i`=1 in the same cycle as `rvfi_valid`. Required: `count_o`=0 and `trace_valid_o`=0 next cycle, `overflow_cnt_o` unchanged. The next record is output alone.
- **Counter saturation and mid-stream reset.** Force 65540 drops. Required: `overflow_cnt_o`=16'hFFFF with no wrap. Then assert `rst_ni`=0 for 1 edge mid-stream. Required: all outputs 0, and the next record with order 1000 is not flagged.
